reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 22 ++
 rtl/slot_match.sv | 19 +
 rtl/reg_scoreboard.sv | 132 +++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared processor package for the register scoreboard.
// Holds the architectural register geometry, the PC index (never tracked)
// and the shadow-slot record that mirrors one pipeline stage.
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 15;
  localparam int IDX_W    = 4;
  localparam logic [IDX_W-1:0] PC_IDX = 4'd15;

  // One shadow pipeline slot: does the stage hold a register writer,
  // which register, and is it a load (result only ready after MEM).
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] dest;
    logic             mem_read;
  } slot_t;

  function automatic slot_t slot_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/slot_match.sv
// Compares one ID-stage source operand against one shadow slot.
// Ports:
//   slot    - shadow slot record {valid, dest, mem_read}
//   src     - source register index
//   src_vld - the source is actually read by the instruction
//   match   - source depends on the slot's pending write
// PC reads never match: the PC is not a tracked register.
module slot_match
  import reg_scoreboard_pkg::*;
(
  input  slot_t            slot,
  input  logic [IDX_W-1:0] src,
  input  logic             src_vld,
  output logic             match
);

  assign match = src_vld & slot.valid & (slot.dest == src) & (src != PC_IDX);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks register writers in EXE/MEM/WB and raises a
// combinational stall request when the instruction in ID reads a result
// that is not yet available.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   freeze                  - memory stall, all slots hold (beats flush)
//   flush                   - kill the instruction in ID
//   fwd_en                  - forwarding present: only load-use stalls
//   id_src1/2, id_src*_vld  - ID source indices and their read enables
//   id_valid/id_wb_en/id_mem_read/id_dest - ID instruction attributes
//   wb_en_in, wb_dest_in    - actual register-file write port
//   hazard                  - stall request to IF/ID
//   pending                 - bit i set when EXE or MEM targets Ri
//   wb_err                  - sticky WB slot vs write-port mismatch
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int IDX_W    = reg_scoreboard_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                fwd_en,
  input  logic [IDX_W-1:0]    id_src1,
  input  logic [IDX_W-1:0]    id_src2,
  input  logic                id_src1_vld,
  input  logic                id_src2_vld,
  input  logic                id_valid,
  input  logic                id_wb_en,
  input  logic                id_mem_read,
  input  logic [IDX_W-1:0]    id_dest,
  input  logic                wb_en_in,
  input  logic [IDX_W-1:0]    wb_dest_in,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending,
  output logic                wb_err
);

  // The register file writes on the falling edge, so a WB-slot hit is
  // readable in the same cycle. Set this if the RF ever moves to a
  // rising-edge write and WB hits must stall too.
  localparam logic WB_STALL = 1'b0;

  localparam int SLOT_EXE = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  slot_t r_exe, r_mem, r_wb;
  logic  r_wb_err;

  slot_t [2:0]            w_slot;
  logic  [1:0][IDX_W-1:0] w_src;
  logic  [1:0]            w_src_vld;
  logic  [1:0][2:0]       w_match;   // [source][slot]

  logic  w_exe_hit, w_mem_hit, w_wb_hit;
  logic  w_issue, w_wb_mismatch;
  slot_t w_exe_next;

  assign w_slot[SLOT_EXE] = r_exe;
  assign w_slot[SLOT_MEM] = r_mem;
  assign w_slot[SLOT_WB]  = r_wb;
  assign w_src            = {id_src2, id_src1};
  assign w_src_vld        = {id_src2_vld, id_src1_vld};

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar k = 0; k < 3; k++) begin : g_slot
      slot_match u_match (
        .slot    (w_slot[k]),
        .src     (w_src[s]),
        .src_vld (w_src_vld[s]),
        .match   (w_match[s][k])
      );
    end
  end

  assign w_exe_hit = w_match[0][SLOT_EXE] | w_match[1][SLOT_EXE];
  assign w_mem_hit = w_match[0][SLOT_MEM] | w_match[1][SLOT_MEM];
  assign w_wb_hit  = w_match[0][SLOT_WB]  | w_match[1][SLOT_WB];

  // With forwarding only a load still in EXE is unresolvable (load-use);
  // without it any EXE/MEM producer stalls the reader.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (fwd_en) hazard = w_exe_hit & r_exe.mem_read;
      else        hazard = w_exe_hit | w_mem_hit;
      hazard = hazard | (WB_STALL & w_wb_hit);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REGS; i++)
      pending[i] = (r_exe.valid && r_exe.dest == IDX_W'(i)) ||
                   (r_mem.valid && r_mem.dest == IDX_W'(i));
  end

  // A stalled or flushed ID instruction, or a PC write, enters EXE as a bubble.
  assign w_issue = id_valid & id_wb_en & ~hazard & ~flush & (id_dest != PC_IDX);

  always_comb begin
    w_exe_next = slot_bubble();
    if (w_issue) begin
      w_exe_next.valid    = 1'b1;
      w_exe_next.dest     = id_dest;
      w_exe_next.mem_read = id_mem_read;
    end
  end

  assign w_wb_mismatch = (r_wb.valid != wb_en_in) ||
                         (r_wb.valid && wb_en_in && (r_wb.dest != wb_dest_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe    <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_wb_err <= 1'b0;
    end else if (!freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= w_exe_next;
      if (w_wb_mismatch) r_wb_err <= 1'b1;
    end
  end

  assign wb_err = r_wb_err;

endmodule
